seg7_reader: RTL and testbench
==============================

Name: seg7_reader

Overview:
- Inverse of the 7-segment display path: samples NUM_DIGITS active-low 8-bit segment buses (same encoding the display decoder drives onto HEX0..HEX5).
- Waits until the whole bus has been stable for STABLE_CYCLES, then scans it one digit per cycle back into packed BCD with per-digit error and decimal-point flags.
- Presents each new frame on a valid/ready output port.
- Used for on-board self-check and loopback of the display outputs.

Parameters:
- NUM_DIGITS, 6: number of 8-bit segment buses read; must be >= 1.
- STABLE_CYCLES, 4: consecutive unchanged cycles required before a frame is accepted; must be >= 1.

Ports:
- clk, input, 1: single clock; every register is on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- hex_in, input, 8*NUM_DIGITS: segment buses, digit 0 (HEX0) at bits [7:0]. Per byte: bit7 = DP, bits6:0 = g..a. All bits active low.
- out_ready, input, 1: consumer accepts the frame.
- out_valid, output, 1: frame available.
- out_bcd, output, 4*NUM_DIGITS: decoded digits, digit 0 at [3:0].
- out_err, output, NUM_DIGITS: 1 = unrecognised segment pattern for that digit.
- out_dp, output, NUM_DIGITS: 1 = DP lit (bit7 == 0) for that digit.

Behaviour:
- Reset (asynchronous on rst_n low, output takes effect immediately):
  - out_valid, out_bcd, out_err, out_dp = 0.
  - state = WAIT; hex_q = all ones; stable_cnt = 0; have_frame = 0; last_frame = 0; idx = 0.
- Stability tracking runs on every edge in every state:
  - hex_q <= hex_in.
  - If hex_in != hex_q: stable_cnt <= 0. Otherwise stable_cnt <= min(stable_cnt+1, STABLE_CYCLES).
  - stable = (stable_cnt == STABLE_CYCLES).
  - stable_cnt width = clog2(STABLE_CYCLES+1).
- Decode of bits6:0 (hex shown):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - 7F (blank) → digit F, err 0.
  - Any other pattern → digit F, err 1.
  - DP is independent of the digit: dp = ~bit7.
- FSM:
  - WAIT: if stable && (!have_frame || hex_q != last_frame) → SCAN, idx <= 0. Otherwise stay.
  - SCAN, each edge:
    - If hex_in != hex_q → WAIT (abort; shadow discarded, last_frame unchanged).
    - Otherwise decode digit idx of hex_q into the shadow registers.
    - If idx == NUM_DIGITS-1: load out_bcd/out_err/out_dp from shadow plus the current digit; last_frame <= hex_q; have_frame <= 1; go to PRESENT.
    - Else idx <= idx+1.
  - PRESENT: out_valid = 1. On out_valid && out_ready → WAIT with out_valid = 0 from the next cycle. Outputs held constant while out_ready = 0.
- Output rules:
  - out_valid is registered and asserted only in PRESENT.
  - out_* change only on the edge entering PRESENT.
- Latency: hex_in takes a new constant value; the first edge sampling it is edge 0. Then:
  - stable true after edge STABLE_CYCLES;
  - SCAN entered at edge STABLE_CYCLES+1;
  - out_valid rises at edge STABLE_CYCLES+NUM_DIGITS+1 (edge 11 for the defaults).
- Boundary cases:
  - Input changes while in PRESENT: ignored for outputs; tracking continues. After the handshake, WAIT re-evaluates immediately, so a changed stable frame scans on the next edge.
  - A glitch shorter than STABLE_CYCLES that returns to last_frame produces no frame.
  - An identical frame is never re-emitted unless have_frame is cleared by reset.

Test Plan:
1. Reset, hold hex_in = {F9,A4,B0,99,92,82} (HEX5..HEX0), out_ready = 1 → out_valid high for exactly 1 cycle at edge 11; out_bcd = 24'h123456, out_err = 0, out_dp = 0. No further valid while hex_in is held.
2. out_ready = 0 after frame 1; change HEX0 to C0 → outputs hold 123456 with out_valid = 1. Raise out_ready → handshake, then the next frame out_bcd = 24'h123450 follows 1+NUM_DIGITS edges later.
3. Glitch: drive HEX2 = 80 for 2 cycles, then restore the original value → no out_valid pulse.
4. Abort: change HEX4 to F9 at edge 8 (mid-SCAN) → no valid at edge 11; out_valid rises 11 edges after the change with out_bcd = 24'h113456.
5. Patterns: HEX0 = FF, HEX1 = 7F, HEX2 = 00, HEX3 = AA, HEX4 = C0, HEX5 = 10 → out_bcd = 24'h90F8FF (digits 0..5 = F,F,8,F,0,9), out_err = 6'b001000, out_dp = 6'b100110.
6. Assert rst_n low while in PRESENT → out_valid drops to 0 immediately (asynchronous). On release with hex_in unchanged, the same frame is re-emitted at edge 11 after release.

Source files
------------

// File: rtl/seg7_reader.sv
// Reads back active-low 7-segment buses into packed BCD frames.
// A frame is scanned only after the bus has settled and differs from the last one.
module seg7_reader #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*NUM_DIGITS-1:0] hex_in,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic [NUM_DIGITS-1:0]   out_dp
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_SCAN,
        S_PRESENT
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [8*NUM_DIGITS-1:0]   r_hex_q;
    logic [8*NUM_DIGITS-1:0]   r_last;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_have;
    logic [IDX_W-1:0]          r_idx;
    logic [4*NUM_DIGITS-1:0]   r_sh_bcd;
    logic [NUM_DIGITS-1:0]     r_sh_err;
    logic [NUM_DIGITS-1:0]     r_sh_dp;
    logic [4*NUM_DIGITS-1:0]   r_bcd;
    logic [NUM_DIGITS-1:0]     r_err;
    logic [NUM_DIGITS-1:0]     r_dp;

    logic                      w_changed;
    logic                      w_stable;
    logic [7:0]                w_seg;
    logic [3:0]                w_dig;
    logic                      w_derr;
    logic [4*NUM_DIGITS-1:0]   w_bcd_n;
    logic [NUM_DIGITS-1:0]     w_err_n;
    logic [NUM_DIGITS-1:0]     w_dp_n;

    assign w_changed = (hex_in != r_hex_q);
    assign w_stable  = (r_cnt == CNT_MAX);
    assign w_seg     = r_hex_q[8*r_idx +: 8];

    always_comb begin
        w_dig  = 4'hF;
        w_derr = 1'b0;
        case (w_seg[6:0])
            7'h40:   w_dig = 4'd0;
            7'h79:   w_dig = 4'd1;
            7'h24:   w_dig = 4'd2;
            7'h30:   w_dig = 4'd3;
            7'h19:   w_dig = 4'd4;
            7'h12:   w_dig = 4'd5;
            7'h02:   w_dig = 4'd6;
            7'h78:   w_dig = 4'd7;
            7'h00:   w_dig = 4'd8;
            7'h10:   w_dig = 4'd9;
            7'h7F:   w_dig = 4'hF;
            default: w_derr = 1'b1;
        endcase
    end

    // Shadow with the digit under the scan pointer merged in.
    always_comb begin
        w_bcd_n               = r_sh_bcd;
        w_err_n               = r_sh_err;
        w_dp_n                = r_sh_dp;
        w_bcd_n[4*r_idx +: 4] = w_dig;
        w_err_n[r_idx]        = w_derr;
        w_dp_n[r_idx]         = ~w_seg[7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_WAIT: begin
                if (w_stable && (!r_have || r_hex_q != r_last))
                    w_next = S_SCAN;
            end
            S_SCAN: begin
                if (w_changed)
                    w_next = S_WAIT;
                else if (r_idx == IDX_LAST)
                    w_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (out_ready)
                    w_next = S_WAIT;
            end
            default: w_next = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex_q  <= '1;
            r_cnt    <= '0;
            r_have   <= 1'b0;
            r_last   <= '0;
            r_idx    <= '0;
            r_sh_bcd <= '0;
            r_sh_err <= '0;
            r_sh_dp  <= '0;
            r_bcd    <= '0;
            r_err    <= '0;
            r_dp     <= '0;
        end else begin
            r_hex_q <= hex_in;
            if (w_changed)
                r_cnt <= '0;
            else if (!w_stable)
                r_cnt <= r_cnt + 1'b1;

            if (r_state == S_WAIT)
                r_idx <= '0;

            if (r_state == S_SCAN && !w_changed) begin
                r_sh_bcd <= w_bcd_n;
                r_sh_err <= w_err_n;
                r_sh_dp  <= w_dp_n;
                if (r_idx == IDX_LAST) begin
                    r_bcd  <= w_bcd_n;
                    r_err  <= w_err_n;
                    r_dp   <= w_dp_n;
                    r_last <= r_hex_q;
                    r_have <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_valid = (r_state == S_PRESENT);
        out_bcd   = r_bcd;
        out_err   = r_err;
        out_dp    = r_dp;
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Vector table plus hand sequences for stability, abort, glitch and reset.
// Expected frames are queued when driven and popped on each handshake.
module tb_seg7_reader;

    typedef struct {
        logic [47:0] hex;
        logic [23:0] bcd;
        logic [5:0]  err;
        logic [5:0]  dp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] hex_in;
    logic        out_ready;
    logic        out_valid;
    logic [23:0] out_bcd;
    logic [5:0]  out_err;
    logic [5:0]  out_dp;

    int   checks = 0;
    int   errors = 0;
    vec_t q[$];
    vec_t tbl[5];

    seg7_reader #(
        .NUM_DIGITS   (6),
        .STABLE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hex_in   (hex_in),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_bcd  (out_bcd),
        .out_err  (out_err),
        .out_dp   (out_dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [47:0] act,
                       input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input string nm, input int exp_e);
        int got;
        got = -1;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                got = e;
                break;
            end
        end
        checks++;
        if (got != exp_e) begin
            errors++;
            $display("FAIL %s edge got=%0d want=%0d", nm, got, exp_e);
        end
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        @(posedge clk);
        #1;
        hex_in = v.hex;
        q.push_back(v);
        wait_valid(nm, 11);
    endtask

    task automatic no_valid(input string nm, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk(nm, 48'(seen), 48'd0);
    endtask

    // Scoreboard: compare each accepted frame against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame bcd=%h", out_bcd);
            end else begin
                vec_t v;
                v = q.pop_front();
                chk("frame_bcd", 48'(out_bcd), 48'(v.bcd));
                chk("frame_err", 48'(out_err), 48'(v.err));
                chk("frame_dp", 48'(out_dp), 48'(v.dp));
            end
        end
    end

    initial begin
        tbl[0] = '{48'hF9A4B0999282, 24'h123456, 6'b000000, 6'b000000};
        tbl[1] = '{48'h10C0AA007FFF, 24'h90F8FF, 6'b001000, 6'b100110};
        tbl[2] = '{48'hC0F9A4B09992, 24'h012345, 6'b000000, 6'b000000};
        tbl[3] = '{48'h027800104079, 24'h678901, 6'b000000, 6'b111111};
        tbl[4] = '{48'hFFFFFFFFFFFF, 24'hFFFFFF, 6'b000000, 6'b000000};

        rst_n     = 1'b1;
        out_ready = 1'b1;
        hex_in    = tbl[0].hex;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 48'(out_valid), 48'd0);
        chk("rst_bcd", 48'(out_bcd), 48'd0);
        chk("rst_err", 48'(out_err), 48'd0);
        chk("rst_dp", 48'(out_dp), 48'd0);

        q.push_back(tbl[0]);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_valid("first_latency", 11);
        @(negedge clk);
        chk("valid_one_cycle", 48'(out_valid), 48'd0);
        no_valid("held_no_reemit", 20);

        for (int i = 1; i < 5; i++)
            apply_vec(tbl[i], $sformatf("tbl%0d_latency", i));

        // Backpressure: outputs hold while the bus changes underneath.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        apply_vec(tbl[0], "bp_latency");
        @(posedge clk);
        #1;
        hex_in = 48'hF9A4B09992C0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_valid", 48'(out_valid), 48'd1);
            chk("bp_bcd", 48'(out_bcd), 48'h123456);
        end
        @(posedge clk);
        #1;
        q.push_back('{48'hF9A4B09992C0, 24'h123450, 6'd0, 6'd0});
        out_ready = 1'b1;
        wait_valid("rescan_latency", 7);

        // Short glitch returning to the last frame.
        @(posedge clk);
        #1;
        hex_in = 48'hF9A4B08092C0;
        repeat (2) @(posedge clk);
        #1;
        hex_in = 48'hF9A4B09992C0;
        no_valid("glitch_no_frame", 30);

        // Bus changes mid-scan: the scan restarts on the new value.
        @(posedge clk);
        #1;
        hex_in = tbl[0].hex;
        repeat (8) @(posedge clk);
        #1;
        hex_in = 48'hF9F9B0999282;
        q.push_back('{48'hF9F9B0999282, 24'h113456, 6'd0, 6'd0});
        wait_valid("abort_latency", 11);

        // Reset while presenting, then re-emit the same frame.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        hex_in = tbl[0].hex;
        q.push_back(tbl[0]);
        wait_valid("pre_reset_latency", 11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 48'(out_valid), 48'd0);
        chk("async_bcd", 48'(out_bcd), 48'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        wait_valid("post_reset_latency", 11);
        @(posedge clk);
        no_valid("final_quiet", 20);
        chk("queue_empty", 48'(q.size()), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
